// File: rtl/mrate_ring_fifo_pkg.sv
// Shared helpers for the multi-rate ring FIFO: address-width and depth-legality functions.
package mrate_ring_fifo_pkg;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // True when 'value' is a non-zero power of two, so that pointers can wrap for free.
  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/mrate_ring_mem.sv
// Ring storage for the multi-rate FIFO: WR_N write lanes and RD_N combinational read lanes.
// Each lane address is the base plus the lane index, wrapping modulo DEPTH, so one
// access may straddle the last entry and the first one. The storage is not reset.
module mrate_ring_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int WR_N  = 4,
  parameter int RD_N  = 4,
  parameter int AW    = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [WR_N*WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [RD_N*WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q      [DEPTH];
  logic [AW-1:0]    wrLaneAddr [WR_N];
  logic [AW-1:0]    rdLaneAddr [RD_N];

  for (genvar g = 0; g < WR_N; g++) begin : gWrLane
    assign wrLaneAddr[g] = waddr_i + AW'(g);
  end

  for (genvar g = 0; g < RD_N; g++) begin : gRdLane
    assign rdLaneAddr[g]              = raddr_i + AW'(g);
    assign rdata_o[g*WIDTH +: WIDTH] = mem_q[rdLaneAddr[g]];
  end

  // Store all write lanes in one cycle; word 0 goes to the base address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WR_N; i++) begin
        mem_q[wrLaneAddr[i]] <= wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mrate_ring_fifo.sv
// Multi-rate circular FIFO: each accepted push writes WR_N words, each accepted pop
// reads RD_N words. Holds pointers, occupancy, handshake decode and sticky error flags.
module mrate_ring_fifo
  import mrate_ring_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int WR_N  = 4,
  parameter int RD_N  = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [WR_N*WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  rd_en_i,
  output logic [RD_N*WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           count_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [AW+1:0] DepthW  = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] WrNW    = (AW+2)'(WR_N);
  localparam logic [AW+1:0] RdNW    = (AW+2)'(RD_N);
  localparam logic [AW-1:0] WrStep  = AW'(WR_N);
  localparam logic [AW-1:0] RdStep  = AW'(RD_N);

  if (!isPow2(DEPTH)) begin : gBadDepth
    $error("mrate_ring_fifo: DEPTH (%0d) must be a power of 2", DEPTH);
  end
  if ((WR_N > DEPTH) || (RD_N > DEPTH)) begin : gBadLanes
    $error("mrate_ring_fifo: WR_N (%0d) and RD_N (%0d) must not exceed DEPTH (%0d)",
           WR_N, RD_N, DEPTH);
  end

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [AW+1:0] countWide;
  logic [AW+1:0] freeSlots;
  logic          wrReady;
  logic          rdValid;
  logic          push;
  logic          pop;

  // Both handshakes depend on the registered count only, so the occupancy can never
  // leave 0..DEPTH even when push and pop happen together.
  assign freeSlots = DepthW - {1'b0, count_q};
  assign wrReady   = freeSlots >= WrNW;
  assign rdValid   = {1'b0, count_q} >= RdNW;
  assign push      = wr_en_i & wrReady & ~clr_i;
  assign pop       = rd_en_i & rdValid & ~clr_i;

  // Next-state decode: clear wins over everything, otherwise apply push/pop and errors.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    countWide = {1'b0, count_q};
    if (clr_i) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      countWide = '0;
    end else begin
      if (push) begin
        wrPtr_d   = wrPtr_q + WrStep;
        countWide = countWide + WrNW;
      end
      if (pop) begin
        rdPtr_d   = rdPtr_q + RdStep;
        countWide = countWide - RdNW;
      end
      if (wr_en_i && !wrReady) begin
        ovf_d = 1'b1;
      end
      if (rd_en_i && !rdValid) begin
        udf_d = 1'b1;
      end
    end
    count_d = countWide[AW:0];
  end

  // Pointer, occupancy and error-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  mrate_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .WR_N  (WR_N),
    .RD_N  (RD_N),
    .AW    (AW)
  ) uMem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wrPtr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rdPtr_q),
    .rdata_o (rd_data_o)
  );

  assign wr_ready_o = wrReady;
  assign full_o     = ~wrReady;
  assign rd_valid_o = rdValid;
  assign empty_o    = ~rdValid;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: tb/tb_mrate_ring_fifo.sv
// Directed bench for mrate_ring_fifo with WIDTH=8, DEPTH=16, WR_N=4, RD_N=3.
// Inputs change just after the falling edge; registered state is read on the next
// falling edge and combinational outputs one time unit after the inputs change.
module tb_mrate_ring_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int WR_N  = 4;
  localparam int RD_N  = 3;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  clr;
  logic                  wrEn;
  logic [WR_N*WIDTH-1:0] wrData;
  logic                  wrReady;
  logic                  rdEn;
  logic [RD_N*WIDTH-1:0] rdData;
  logic                  rdValid;
  logic                  full;
  logic                  empty;
  logic [4:0]            count;
  logic                  ovf;
  logic                  udf;

  int assertCount = 0;
  int failCount   = 0;

  mrate_ring_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .WR_N  (WR_N),
    .RD_N  (RD_N)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .clr_i      (clr),
    .wr_en_i    (wrEn),
    .wr_data_i  (wrData),
    .wr_ready_o (wrReady),
    .rd_en_i    (rdEn),
    .rd_data_o  (rdData),
    .rd_valid_o (rdValid),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .ovf_o      (ovf),
    .udf_o      (udf)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wrEnIn, input logic [31:0] wrDataIn,
                               input logic rdEnIn, input logic clrIn);
    wrEn   = wrEnIn;
    wrData = wrDataIn;
    rdEn   = rdEnIn;
    clr    = clrIn;
    #1;
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    rstN   = 1'b0;
    clr    = 1'b0;
    wrEn   = 1'b0;
    wrData = '0;
    rdEn   = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_wr_ready", 32'(wrReady), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_rd_valid", 32'(rdValid), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);

    // Pop while empty sets udf, then one push so there is state to lose.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("pre_udf", 32'(udf), 32'd1);
    applyStimulus(1'b1, 32'h03020100, 1'b0, 1'b0);
    nextCycle();
    checkOutput("pre_count", 32'(count), 32'd4);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_udf", 32'(udf), 32'd0);
    nextCycle();
    rstN = 1'b1;
    #1;
    checkOutput("post_rst_count", 32'(count), 32'd0);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);
    checkOutput("post_rst_full", 32'(full), 32'd0);
    checkOutput("post_rst_rd_valid", 32'(rdValid), 32'd0);
    checkOutput("post_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("post_rst_udf", 32'(udf), 32'd0);

    $display("[TB] fill and overflow");
    applyStimulus(1'b1, 32'h03020100, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h07060504, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h0B0A0908, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h0F0E0D0C, 1'b0, 1'b0);
    nextCycle();
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_wr_ready", 32'(wrReady), 32'd0);
    checkOutput("fill_ovf_clear", 32'(ovf), 32'd0);
    applyStimulus(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    nextCycle();
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);

    $display("[TB] drain and underflow");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop0_valid", 32'(rdValid), 32'd1);
    checkOutput("pop0_data", 32'(rdData), 32'h020100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop1_data", 32'(rdData), 32'h050403);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop2_data", 32'(rdData), 32'h080706);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop3_data", 32'(rdData), 32'h0B0A09);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop4_data", 32'(rdData), 32'h0E0D0C);
    nextCycle();
    checkOutput("drain_count", 32'(count), 32'd1);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_udf_clear", 32'(udf), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("udf_set", 32'(udf), 32'd1);
    checkOutput("udf_count", 32'(count), 32'd1);

    $display("[TB] wrap-around");
    applyStimulus(1'b1, 32'h33323130, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h37363534, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h3B3A3938, 1'b0, 1'b0);
    nextCycle();
    checkOutput("wrap_count", 32'(count), 32'd13);

    // Push refused (3 free) while the pop straddles 15 -> 0.
    applyStimulus(1'b1, 32'h43424140, 1'b1, 1'b0);
    checkOutput("refuse_wr_ready", 32'(wrReady), 32'd0);
    checkOutput("refuse_rd_valid", 32'(rdValid), 32'd1);
    checkOutput("wrap_pop0_data", 32'(rdData), 32'h31300F);
    nextCycle();
    checkOutput("refuse_count", 32'(count), 32'd10);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("wrap_pop1_data", 32'(rdData), 32'h343332);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("wrap_pop2_data", 32'(rdData), 32'h373635);
    nextCycle();
    checkOutput("wrap_count_after", 32'(count), 32'd4);

    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b1, 32'h43424140, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("mix_pop0_data", 32'(rdData), 32'h3A3938);
    nextCycle();
    applyStimulus(1'b1, 32'h47464544, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("mix_pop1_data", 32'(rdData), 32'h41403B);
    nextCycle();
    checkOutput("sim_start_count", 32'(count), 32'd6);
    applyStimulus(1'b1, 32'h4B4A4948, 1'b1, 1'b0);
    checkOutput("sim_wr_ready", 32'(wrReady), 32'd1);
    checkOutput("sim_pop_data", 32'(rdData), 32'h444342);
    nextCycle();
    checkOutput("sim_count", 32'(count), 32'd7);
    applyStimulus(1'b1, 32'h4F4E4D4C, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h53525150, 1'b0, 1'b0);
    nextCycle();
    checkOutput("near_full_count", 32'(count), 32'd15);
    checkOutput("near_full_full", 32'(full), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("sim_pop1_data", 32'(rdData), 32'h474645);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("sim_pop2_data", 32'(rdData), 32'h4A4948);
    nextCycle();
    checkOutput("pre_clr_count", 32'(count), 32'd9);
    checkOutput("pre_clr_ovf", 32'(ovf), 32'd1);

    $display("[TB] clear");
    applyStimulus(1'b1, 32'h63626160, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_empty", 32'(empty), 32'd1);
    checkOutput("clr_full", 32'(full), 32'd0);
    checkOutput("clr_ovf", 32'(ovf), 32'd0);
    checkOutput("clr_udf", 32'(udf), 32'd0);
    applyStimulus(1'b1, 32'h73727170, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_clr_count", 32'(count), 32'd4);
    checkOutput("post_clr_rd_valid", 32'(rdValid), 32'd1);
    checkOutput("post_clr_data", 32'(rdData), 32'h727170);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
